// File: rtl/spi_master_cmd.sv
// SPI master for the register-slave bus: one command per cs frame, address byte then Nbit data.
// sclk/mosi/cs come straight from flops; miso is sampled at the end of each sclk high half.
module spi_master_cmd #(
  parameter int Nbit    = 8,
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_rw,
  input  logic [6:0]      cmd_addr,
  input  logic [Nbit-1:0] cmd_wdata,
  output logic            rsp_valid,
  output logic [Nbit-1:0] rsp_rdata,
  output logic            busy,
  output logic            sclk,
  output logic            mosi,
  input  logic            miso,
  output logic            cs
);

  localparam int FW    = 8 + Nbit;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(FW);
  localparam int GAP_W = $clog2(CS_GAP);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FW - 1);
  localparam logic [BIT_W-1:0] BIT_DATA0 = BIT_W'(8);
  // The IDLE cycle before the next accept also has cs high, so GAP itself lasts CS_GAP-1 cycles.
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(CS_GAP - 2);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [1:0]       r_state;
  logic [DIV_W-1:0] r_div;
  logic [BIT_W-1:0] r_bit;
  logic [GAP_W-1:0] r_gap;
  logic             r_sclk;
  logic             r_mosi;
  logic             r_cs;
  logic             r_rsp_valid;
  logic [Nbit-1:0]  r_rsp_rdata;
  logic [FW-1:0]    r_tx;
  logic [Nbit-1:0]  r_rx;

  logic            w_accept;
  logic            w_half_end;
  logic            w_sample;
  logic            w_advance;
  logic [FW-1:0]   w_frame;

  assign w_accept   = (r_state == S_IDLE) && cmd_valid;
  assign w_half_end = (r_div == DIV_LAST);
  assign w_sample   = (r_state == S_SHIFT) && w_half_end && r_sclk;
  assign w_advance  = w_sample && (r_bit != BIT_LAST);
  assign w_frame    = {cmd_rw, cmd_addr, (cmd_rw ? cmd_wdata : {Nbit{1'b0}})};

  // Control path: FSM, counters and every bus-visible output
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_div       <= '0;
      r_bit       <= '0;
      r_gap       <= '0;
      r_sclk      <= 1'b0;
      r_mosi      <= 1'b0;
      r_cs        <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cs   <= 1'b1;
          r_sclk <= 1'b0;
          if (w_accept) begin
            r_state <= S_SHIFT;
            r_cs    <= 1'b0;
            r_mosi  <= w_frame[FW-1];
            r_div   <= '0;
            r_bit   <= '0;
          end
        end
        S_SHIFT: begin
          if (w_half_end) begin
            r_div <= '0;
            if (!r_sclk) begin
              r_sclk <= 1'b1;
            end else if (r_bit == BIT_LAST) begin
              r_sclk  <= 1'b0;
              r_mosi  <= 1'b0;
              r_state <= S_HOLD;
            end else begin
              // mosi only moves together with the falling sclk edge
              r_sclk <= 1'b0;
              r_mosi <= r_tx[FW-1];
              r_bit  <= r_bit + BIT_W'(1);
            end
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        S_HOLD: begin
          if (w_half_end) begin
            r_div       <= '0;
            r_gap       <= '0;
            r_cs        <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_rx;
            r_state     <= S_GAP;
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        default: begin
          if (r_gap == GAP_LAST) begin
            r_state <= S_IDLE;
          end else begin
            r_gap <= r_gap + GAP_W'(1);
          end
        end
      endcase
    end
  end

  // Data path: transmit and receive shift registers
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_tx <= {w_frame[FW-2:0], 1'b0};
    end else if (w_advance) begin
      r_tx <= {r_tx[FW-2:0], 1'b0};
    end
    if (w_sample && (r_bit >= BIT_DATA0)) begin
      r_rx <= Nbit'({r_rx, miso});
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign sclk      = r_sclk;
  assign mosi      = r_mosi;
  assign cs        = r_cs;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_spi_master_cmd.sv
// Directed bench: two masters (8-bit/div4 and 16-bit/div8) each talking to a behavioural register slave.
module tb_spi_master_cmd;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A: Nbit=8, CLK_DIV=4, CS_GAP=8
  logic       a_valid = 1'b0, a_rw = 1'b0;
  logic [6:0] a_addr = '0;
  logic [7:0] a_wdata = '0;
  logic       a_ready, a_rsp_valid, a_busy, a_sclk, a_mosi, a_cs;
  logic [7:0] a_rdata;
  logic       a_miso = 1'b1;

  spi_master_cmd #(.Nbit(8), .CLK_DIV(4), .CS_GAP(8)) u_dut_a (
    .clk(clk), .rst(rst), .cmd_valid(a_valid), .cmd_ready(a_ready), .cmd_rw(a_rw),
    .cmd_addr(a_addr), .cmd_wdata(a_wdata), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata),
    .busy(a_busy), .sclk(a_sclk), .mosi(a_mosi), .miso(a_miso), .cs(a_cs));

  // DUT B: Nbit=16, CLK_DIV=8, CS_GAP=8
  logic        b_valid = 1'b0, b_rw = 1'b0;
  logic [6:0]  b_addr = '0;
  logic [15:0] b_wdata = '0;
  logic        b_ready, b_rsp_valid, b_busy, b_sclk, b_mosi, b_cs;
  logic [15:0] b_rdata;
  logic        b_miso = 1'b1;

  spi_master_cmd #(.Nbit(16), .CLK_DIV(8), .CS_GAP(8)) u_dut_b (
    .clk(clk), .rst(rst), .cmd_valid(b_valid), .cmd_ready(b_ready), .cmd_rw(b_rw),
    .cmd_addr(b_addr), .cmd_wdata(b_wdata), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata),
    .busy(b_busy), .sclk(b_sclk), .mosi(b_mosi), .miso(b_miso), .cs(b_cs));

  // Slave A state and bus monitors (all sampled on the falling clk edge)
  logic [7:0]  sa_mem [128];
  logic [15:0] sa_frame = '0;
  logic [7:0]  sa_out = '0;
  logic        sa_drive = 1'b0, sa_psclk = 1'b0, sa_pmosi = 1'b0, sa_pcs = 1'b1;
  int          sa_cnt = 0, a_viol = 0, a_tfall = -1, a_trise = -1, a_gap = -1;
  int          a_rsp_n = 0, a_trsp = -1;
  logic [7:0]  a_last_rd = '0;

  always @(negedge clk) begin
    if (a_cs) begin
      sa_cnt = 0; sa_drive = 1'b0; a_miso = 1'b1;
    end else begin
      if (a_sclk && !sa_psclk) begin
        sa_frame = {sa_frame[14:0], a_mosi};
        sa_cnt++;
        if (sa_cnt == 8) begin
          sa_drive = !sa_frame[7] && (sa_frame[6:0] != 7'h05);
          sa_out   = sa_mem[sa_frame[6:0]];
        end
        if (sa_cnt == 16 && sa_frame[15] && sa_frame[14:8] != 7'h05) sa_mem[sa_frame[14:8]] = sa_frame[7:0];
      end
      if (!a_sclk && sa_psclk && sa_cnt >= 8 && sa_drive) begin
        a_miso = sa_out[7]; sa_out = {sa_out[6:0], 1'b0};
      end
      if (a_sclk && sa_psclk && (a_mosi !== sa_pmosi)) a_viol++;
    end
    if (!a_cs && sa_pcs) begin
      if (a_trise >= 0) a_gap = cyc - a_trise;
      a_tfall = cyc;
    end
    if (a_cs && !sa_pcs) a_trise = cyc;
    if (a_rsp_valid) begin a_rsp_n++; a_last_rd = a_rdata; a_trsp = cyc; end
    sa_psclk = a_sclk; sa_pmosi = a_mosi; sa_pcs = a_cs;
  end

  // Slave B state and bus monitors
  logic [15:0] sb_mem [128];
  logic [23:0] sb_frame = '0;
  logic [15:0] sb_out = '0;
  logic        sb_drive = 1'b0, sb_psclk = 1'b0, sb_pmosi = 1'b0, sb_pcs = 1'b1;
  int          sb_cnt = 0, b_viol = 0, b_tfall = -1, b_trise = -1, b_prise = -1, b_per = -1;
  int          b_rsp_n = 0, b_trsp = -1;
  logic [15:0] b_last_rd = '0;

  always @(negedge clk) begin
    if (b_cs) begin
      sb_cnt = 0; sb_drive = 1'b0; b_miso = 1'b1;
    end else begin
      if (b_sclk && !sb_psclk) begin
        sb_frame = {sb_frame[22:0], b_mosi};
        sb_cnt++;
        if (b_prise >= 0) b_per = cyc - b_prise;
        b_prise = cyc;
        if (sb_cnt == 8) begin
          sb_drive = !sb_frame[7] && (sb_frame[6:0] != 7'h05);
          sb_out   = sb_mem[sb_frame[6:0]];
        end
        if (sb_cnt == 24 && sb_frame[23]) sb_mem[sb_frame[22:16]] = sb_frame[15:0];
      end
      if (!b_sclk && sb_psclk && sb_cnt >= 8 && sb_drive) begin
        b_miso = sb_out[15]; sb_out = {sb_out[14:0], 1'b0};
      end
      if (b_sclk && sb_psclk && (b_mosi !== sb_pmosi)) b_viol++;
    end
    if (!b_cs && sb_pcs) b_tfall = cyc;
    if (b_cs && !sb_pcs) b_trise = cyc;
    if (b_rsp_valid) begin b_rsp_n++; b_last_rd = b_rdata; b_trsp = cyc; end
    sb_psclk = b_sclk; sb_pmosi = b_mosi; sb_pcs = b_cs;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready_a();
    int k = 0;
    while (!a_ready && k < 1000) begin tick(); k++; end
    if (k >= 1000) check("a_ready_timeout", 32'(k), 32'd0);
  endtask

  // One command on A; optional mid-transfer cmd_valid pulse that must be ignored
  task automatic txn_a(input logic rw, input logic [6:0] addr, input logic [7:0] wd,
                       input bit glitch, output int t_acc);
    int n0 = a_rsp_n;
    int k = 0;
    wait_ready_a();
    a_rw = rw; a_addr = addr; a_wdata = wd; a_valid = 1'b1;
    tick();
    t_acc = cyc;
    a_valid = 1'b0;
    if (glitch) begin
      repeat (20) tick();
      a_valid = 1'b1; a_rw = 1'b1; a_addr = 7'h09; a_wdata = 8'hEE;
      check("ready_low_busy", 32'(a_ready), 32'd0);
      tick();
      a_valid = 1'b0;
    end
    while (a_rsp_n == n0 && k < 2000) begin tick(); k++; end
    check("a_rsp_seen", 32'(a_rsp_n - n0), 32'd1);
  endtask

  task automatic txn_b(input logic rw, input logic [6:0] addr, input logic [15:0] wd, output int t_acc);
    int n0 = b_rsp_n;
    int k = 0;
    while (!b_ready && k < 1000) begin tick(); k++; end
    b_rw = rw; b_addr = addr; b_wdata = wd; b_valid = 1'b1;
    tick();
    t_acc = cyc;
    b_valid = 1'b0;
    k = 0;
    while (b_rsp_n == n0 && k < 3000) begin tick(); k++; end
    check("b_rsp_seen", 32'(b_rsp_n - n0), 32'd1);
  endtask

  initial begin
    int t, n0, g1, g2, k;
    for (int i = 0; i < 128; i++) begin sa_mem[i] = 8'h00; sb_mem[i] = 16'h0000; end

    // Reset state
    repeat (3) tick();
    check("rst_cs", 32'(a_cs), 32'd1);
    check("rst_sclk", 32'(a_sclk), 32'd0);
    check("rst_mosi", 32'(a_mosi), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("rst_rdata", 32'(a_rdata), 32'd0);
    rst = 1'b0;
    tick();
    check("rst_ready", 32'(a_ready), 32'd1);

    // 1: write 0xA5 to addr 0x01
    txn_a(1'b1, 7'h01, 8'hA5, 1'b0, t);
    check("t1_mosi_frame", 32'(sa_frame), 32'h81A5);
    check("t1_cs_low", 32'(a_trise - a_tfall), 32'd132);
    check("t1_cs_fall", 32'(a_tfall - t), 32'd0);
    check("t1_rsp_lat", 32'(a_trsp - t), 32'd132);
    check("t1_slave_reg", 32'(sa_mem[1]), 32'hA5);

    // 2: read addr 0x01 returning 0x3C, with an ignored mid-transfer pulse
    sa_mem[1] = 8'h3C;
    txn_a(1'b0, 7'h01, 8'h77, 1'b1, t);
    n0 = a_rsp_n;
    check("t2_rdata", 32'(a_last_rd), 32'h3C);
    check("t2_mosi_frame", 32'(sa_frame), 32'h0100);
    repeat (40) tick();
    check("t2_no_extra_rsp", 32'(a_rsp_n - n0), 32'd0);
    check("t2_no_extra_cs", 32'(a_cs), 32'd1);
    check("t2_glitch_ignored", 32'(sa_mem[9]), 32'h00);

    // 3: read absent address
    txn_a(1'b0, 7'h05, 8'h00, 1'b0, t);
    check("t3_absent_rdata", 32'(a_last_rd), 32'hFF);

    // 4: three back-to-back writes with cmd_valid held high
    n0 = a_rsp_n;
    wait_ready_a();
    a_rw = 1'b1; a_addr = 7'h02; a_wdata = 8'h11; a_valid = 1'b1;
    tick();
    repeat (10) tick();
    a_addr = 7'h03; a_wdata = 8'h22;
    check("t4_ready_low", 32'(a_ready), 32'd0);
    check("t4_busy_high", 32'(a_busy), 32'd1);
    wait_ready_a();
    tick();
    tick();
    g1 = a_gap;
    a_addr = 7'h04; a_wdata = 8'h33;
    wait_ready_a();
    tick();
    a_valid = 1'b0;
    tick();
    g2 = a_gap;
    k = 0;
    while (a_rsp_n < n0 + 3 && k < 2000) begin tick(); k++; end
    check("t4_rsp_count", 32'(a_rsp_n - n0), 32'd3);
    check("t4_gap1", 32'(g1), 32'd8);
    check("t4_gap2", 32'(g2), 32'd8);
    check("t4_reg2", 32'(sa_mem[2]), 32'h11);
    check("t4_reg3", 32'(sa_mem[3]), 32'h22);
    check("t4_reg4", 32'(sa_mem[4]), 32'h33);

    // 5: reset mid-frame at bit 10, then a fresh write
    n0 = a_rsp_n;
    wait_ready_a();
    a_rw = 1'b1; a_addr = 7'h06; a_wdata = 8'h77; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    k = 0;
    while (sa_cnt < 10 && k < 500) begin tick(); k++; end
    check("t5_reached_bit10", 32'(sa_cnt), 32'd10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_cs", 32'(a_cs), 32'd1);
    check("t5_sclk", 32'(a_sclk), 32'd0);
    check("t5_mosi", 32'(a_mosi), 32'd0);
    check("t5_busy", 32'(a_busy), 32'd0);
    check("t5_rdata", 32'(a_rdata), 32'd0);
    check("t5_ready", 32'(a_ready), 32'd1);
    repeat (200) tick();
    check("t5_no_rsp", 32'(a_rsp_n - n0), 32'd0);
    check("t5_reg_untouched", 32'(sa_mem[6]), 32'h00);
    txn_a(1'b1, 7'h06, 8'h5A, 1'b0, t);
    check("t5_new_write", 32'(sa_mem[6]), 32'h5A);
    check("a_mosi_stable", 32'(a_viol), 32'd0);

    // 6: 16-bit data, CLK_DIV=8
    txn_b(1'b1, 7'h07, 16'hBEEF, t);
    check("t6_cs_low", 32'(b_trise - b_tfall), 32'd392);
    check("t6_rsp_lat", 32'(b_trsp - t), 32'd392);
    check("t6_sclk_period", 32'(b_per), 32'd16);
    check("t6_mosi_frame", 32'(sb_frame), 32'h87BEEF);
    check("t6_slave_reg", 32'(sb_mem[7]), 32'hBEEF);
    txn_b(1'b0, 7'h07, 16'h1234, t);
    check("t6_read_frame", 32'(sb_frame), 32'h070000);
    check("t6_rdata", 32'(b_last_rd), 32'hBEEF);
    check("b_mosi_stable", 32'(b_viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
